databus_ctrl: RTL and testbench

- Data-side bus controller between the pipeline MEM stage and the slow three-level storage path (cache/SDRAM).
- Accepts one load/store from MEM and runs a req/ack transaction on the memory side. Returns load data.
- Generates the databus_busy/databus_done levels that the pipeline stall controller uses to freeze all six stages while an access is outstanding.

---
 rtl/databus_ctrl.sv | 79 +++++++
 tb/tb_databus_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/databus_ctrl.sv
// databus_ctrl: MEM-stage load/store bus controller with req/ack memory handshake and pipeline stall levels.
// Optional watchdog timeout enabled by defining DATABUS_TIMEOUT_EN.
module databus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_sel,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                databus_busy,
  output logic                databus_done,
  output logic                bus_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_sel,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic tmo;
`ifdef DATABUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic err;
  always_ff @(posedge clk) begin
    cnt <= (rst || state != REQ) ? '0 : cnt + 1'b1;
    err <= rst ? 1'b0 : err | tmo;
  end
  // cnt holds the number of REQ cycles already elapsed, so this fires in the last allowed one
  assign tmo = state == REQ && !mem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign bus_err = err;
`else
  assign tmo = 1'b0;
  assign bus_err = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = cpu_req ? REQ : IDLE;
      REQ:     state_nx = (mem_ack || tmo) ? DONE : REQ;
      default: state_nx = IDLE;
    endcase
  end
  assign databus_busy = state == REQ;
  assign mem_req = state == REQ;
  // Combinational in IDLE so the pipeline freezes in the same cycle the request appears
  assign databus_done = state == DONE || (state == IDLE && !cpu_req);
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sel   <= '0;
      cpu_rdata <= '0;
    end else begin
      if (state == IDLE && cpu_req) begin
        mem_we    <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        mem_sel   <= cpu_sel;
      end
      if (state == REQ && mem_ack && !mem_we)
        cpu_rdata <= mem_rdata;
      else if (tmo)
        cpu_rdata <= '0;
    end
  end
endmodule

// File: tb/tb_databus_ctrl.sv
// tb_databus_ctrl: randomized scoreboard bench for databus_ctrl; driver pushes expected completions, negedge monitor checks.
module tb_databus_ctrl;
  localparam int TO = 4;
`ifdef DATABUS_TIMEOUT_EN
  localparam int KMAX = TO;
`else
  localparam int KMAX = 6;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0] cpu_sel = '0;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [3:0] mem_sel;
  logic busy, done, bus_err, mem_req, mem_we;
  logic mem_ack = 1'b0;

  databus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_sel(cpu_sel), .cpu_rdata(cpu_rdata),
    .databus_busy(busy), .databus_done(done), .bus_err(bus_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  typedef struct {
    bit we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] sel;
    int cyc;
    bit err;
  } exp_t;
  exp_t q[$];
  int n_tests = 0, n_fail = 0;
  logic [31:0] drv_rd = '0;
  bit drv_err = 1'b0;
  logic [31:0] mon_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory-side ack after k REQ cycles (k=0: never ack, rely on timeout)
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sel, input int k, input logic [31:0] rd, input bit hold);
    exp_t e;
    int n;
    n = (k == 0) ? TO : k;
    if (k == 0) begin
      drv_rd = '0;
      drv_err = 1'b1;
    end else if (!we)
      drv_rd = rd;
    e.we = we; e.addr = a; e.wdata = wd; e.sel = sel; e.rdata = drv_rd; e.cyc = n; e.err = drv_err;
    q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_sel = sel; mem_ack = 1'b0;
    @(posedge clk); #1;
    repeat (n - 1) begin
      mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    if (k != 0) begin
      mem_ack = 1'b1;
      mem_rdata = rd;
    end
    @(posedge clk); #1;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(posedge clk); #1;
    if (!hold) cpu_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  endtask

  task automatic reset_mid();
    exp_t e;
    e.we = 1'b0; e.addr = 32'h200; e.wdata = '0; e.sel = 4'hf; e.rdata = '0; e.cyc = 0; e.err = 1'b0;
    q.push_back(e);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200; cpu_wdata = '0; cpu_sel = 4'hf; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    drv_rd = '0;
    drv_err = 1'b0;
  endtask

  bit prev_busy = 1'b0, prev_rst = 1'b0;
  int cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (prev_rst) begin
      chk("reset busy", busy, 0);
      chk("reset mem_req", mem_req, 0);
      chk("reset done", done, !cpu_req);
      chk("reset cpu_rdata", cpu_rdata, 0);
      chk("reset bus_err", bus_err, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset mem_we", mem_we, 0);
      q.delete();
      mon_rd = '0;
      cnt = 0;
    end else if (busy) begin
      chk("done in REQ", done, 0);
      chk("mem_req in REQ", mem_req, 1);
      if (!prev_busy) begin
        if (q.size() == 0)
          chk("unexpected request", 1, 0);
        else begin
          chk("mem_we", mem_we, q[0].we);
          chk("mem_addr", mem_addr, q[0].addr);
          chk("mem_wdata", mem_wdata, q[0].wdata);
          chk("mem_sel", mem_sel, q[0].sel);
        end
      end
      cnt++;
    end else if (prev_busy) begin
      chk("done in DONE", done, 1);
      chk("mem_req in DONE", mem_req, 0);
      if (q.size() == 0)
        chk("unexpected completion", 1, 0);
      else begin
        e = q.pop_front();
        chk("cpu_rdata", cpu_rdata, e.rdata);
        chk("req cycles", cnt, e.cyc);
        chk("bus_err", bus_err, e.err);
        mon_rd = e.rdata;
      end
      cnt = 0;
    end else begin
      chk("idle done", done, !cpu_req);
      chk("idle mem_req", mem_req, 0);
      chk("idle cpu_rdata", cpu_rdata, mon_rd);
    end
    prev_busy = busy;
    prev_rst = rst;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bit we, hold;
    int k;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    access(1'b0, 32'h40, 32'h0, 4'hf, 3, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    access(1'b1, 32'h10, 32'h1234_5678, 4'b0011, 1, 32'h5555_AAAA, 1'b0);
    idle(2);
    access(1'b0, 32'h100, 32'h0, 4'hf, 2, 32'hA5A5_0001, 1'b1);
    access(1'b0, 32'h104, 32'h0, 4'hf, 1, 32'h0102_0304, 1'b0);
    idle(2);
    reset_mid();
    idle(2);
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      k = $urandom_range(1, KMAX);
      hold = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      access(we, $urandom, $urandom, 4'($urandom), k, $urandom, hold);
      if (!hold) idle($urandom_range(0, 3));
    end
`ifdef DATABUS_TIMEOUT_EN
    idle(1);
    access(1'b0, 32'h300, 32'h0, 4'hf, TO, 32'h7777_8888, 1'b0);
    idle(1);
    access(1'b0, 32'h304, 32'h0, 4'hf, 0, 32'h0, 1'b0);
    idle(2);
    access(1'b1, 32'h308, 32'hCAFE_F00D, 4'b1100, 2, 32'h0, 1'b0);
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drv_rd = '0;
    drv_err = 1'b0;
    idle(2);
`endif
    idle(3);
    chk("queue drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
